// File: rtl/reflex_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reflex_pkg : shared widths, default parameters and saturation helpers     |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package reflex_pkg;

  localparam int DEF_X_W        = 10;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int DEF_HOLD_LINES = 8;
  localparam int MASS_W         = 20;
  localparam int MOM_W          = 32;
  localparam int MET_W          = 24;
  localparam int POT_W          = 16;

  // Signed add that pins to the most positive / most negative value on overflow.
  function automatic logic signed [MOM_W-1:0] sat_add_s(input logic signed [MOM_W-1:0] a,
                                                        input logic signed [MOM_W-1:0] b);
    logic [MOM_W:0] s;
    s = {a[MOM_W-1], a} + {b[MOM_W-1], b};
    if (s[MOM_W] != s[MOM_W-1])
      return s[MOM_W] ? {1'b1, {(MOM_W-1){1'b0}}} : {1'b0, {(MOM_W-1){1'b1}}};
    return s[MOM_W-1:0];
  endfunction

  // Magnitude of a two's-complement value, clamped to the metric width.
  function automatic logic [MET_W-1:0] sat_mag(input logic [MOM_W:0] v);
    logic [MOM_W:0] m;
    m = v[MOM_W] ? (~v + (MOM_W+1)'(1)) : v;
    return (m > {{(MOM_W-MET_W+1){1'b0}}, {MET_W{1'b1}}}) ? {MET_W{1'b1}} : m[MET_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/reflex_lif_neuron.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reflex_lif_neuron : leaky integrate-and-fire neuron, one update per line  |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
module reflex_lif_neuron
  import reflex_pkg::*;
#(
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic             drift_spk,
  input  logic             spread_spk,
  input  logic             shock_spk,
  input  logic [POT_W-1:0] w_drift,
  input  logic [POT_W-1:0] w_spread,
  input  logic [POT_W-1:0] w_shock,
  input  logic [POT_W-1:0] snn_threshold,
  output logic             fire_now,
  output logic             fire
);

  logic [POT_W-1:0] r_v;
  logic [POT_W+1:0] w_sum;
  logic [POT_W-1:0] w_vn;

  // Two guard bits hold the leaked potential plus all three weights without wrap.
  always_comb begin
    w_sum = {2'b00, r_v - (r_v >> LEAK_SHIFT)};
    if (drift_spk)  w_sum = w_sum + {2'b00, w_drift};
    if (spread_spk) w_sum = w_sum + {2'b00, w_spread};
    if (shock_spk)  w_sum = w_sum + {2'b00, w_shock};
    w_vn     = (w_sum > {2'b00, {POT_W{1'b1}}}) ? {POT_W{1'b1}} : w_sum[POT_W-1:0];
    fire_now = update && (w_vn > snn_threshold);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v  <= '0;
      fire <= 1'b0;
    end else begin
      fire <= fire_now;
      if (update) r_v <= fire_now ? '0 : w_vn;
    end
  end

endmodule
`default_nettype wire

// File: rtl/top_reflex_system.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | top_reflex_system : per-line feature extraction, LIF reflex, torque mux   |
// | Option REFLEX_LATCH_EN latches the override until reset. Revision : 1.0   |
// +--------------------------------------------------------------------------+
module top_reflex_system
  import reflex_pkg::*;
#(
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int HOLD_LINES = DEF_HOLD_LINES,
  parameter int X_W        = DEF_X_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_pixel,
  input  logic                    end_of_line,
  input  logic [7:0]              pixel_val,
  input  logic [X_W-1:0]          x_coord,
  input  logic [X_W-1:0]          center_x,
  input  logic signed [15:0]      policy_torque,
  input  logic [MET_W-1:0]        drift_thresh,
  input  logic [MOM_W-1:0]        spread_thresh,
  input  logic [MET_W-1:0]        change_thresh,
  input  logic [POT_W-1:0]        w_drift,
  input  logic [POT_W-1:0]        w_spread,
  input  logic [POT_W-1:0]        w_shock,
  input  logic [POT_W-1:0]        snn_threshold,
  input  logic signed [15:0]      safe_torque,
  output logic signed [15:0]      final_command,
  output logic                    reflex_active,
  output logic                    override_status
);

  localparam int c_PW = X_W + 10;

  logic [MASS_W-1:0]       r_m, w_m_nxt;
  logic signed [MOM_W-1:0] r_s1, w_s1_nxt, r_prev;
  logic [X_W-1:0]          r_xmin, r_xmax, w_xmin_nxt, w_xmax_nxt, w_span;
  logic                    r_prev_vld, r_met_vld;
  logic                    r_drift_spk, r_spread_spk, r_shock_spk;
  logic signed [X_W:0]     w_diff;
  logic signed [c_PW-1:0]  w_prod;
  logic [MOM_W:0]          w_dc;
  logic [MET_W-1:0]        w_d, w_c;
  logic [MOM_W-1:0]        w_sp;
  logic                    w_line_hit, w_fire_now;

  always_comb begin
    w_diff     = $signed({1'b0, x_coord}) - $signed({1'b0, center_x});
    w_prod     = c_PW'($signed({1'b0, pixel_val})) * c_PW'(w_diff);
    w_m_nxt    = r_m;
    w_s1_nxt   = r_s1;
    w_xmin_nxt = r_xmin;
    w_xmax_nxt = r_xmax;
    if (valid_pixel) begin
      w_m_nxt  = r_m + MASS_W'(pixel_val);
      w_s1_nxt = sat_add_s(r_s1, MOM_W'(w_prod));
      if (pixel_val != '0) begin
        if (x_coord < r_xmin) w_xmin_nxt = x_coord;
        if (x_coord > r_xmax) w_xmax_nxt = x_coord;
      end
    end
    // Metrics use the *_nxt values so a pixel on the end_of_line cycle is included.
    w_line_hit = (w_m_nxt != '0);
    w_span     = w_xmax_nxt - w_xmin_nxt;
    w_sp       = w_line_hit ? {{(MOM_W-X_W){1'b0}}, w_span} : '0;
    w_d        = sat_mag({w_s1_nxt[MOM_W-1], w_s1_nxt});
    w_dc       = {w_s1_nxt[MOM_W-1], w_s1_nxt} - {r_prev[MOM_W-1], r_prev};
    w_c        = r_prev_vld ? sat_mag(w_dc) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m          <= '0;
      r_s1         <= '0;
      r_xmin       <= '1;
      r_xmax       <= '0;
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_met_vld    <= 1'b0;
      r_drift_spk  <= 1'b0;
      r_spread_spk <= 1'b0;
      r_shock_spk  <= 1'b0;
    end else begin
      r_met_vld <= end_of_line;
      if (end_of_line) begin
        r_m          <= '0;
        r_s1         <= '0;
        r_xmin       <= '1;
        r_xmax       <= '0;
        r_drift_spk  <= w_line_hit && (w_d > drift_thresh);
        r_spread_spk <= w_line_hit && (w_sp > spread_thresh);
        r_shock_spk  <= w_line_hit && (w_c > change_thresh);
        if (w_line_hit) begin
          r_prev     <= w_s1_nxt;
          r_prev_vld <= 1'b1;
        end
      end else begin
        r_m    <= w_m_nxt;
        r_s1   <= w_s1_nxt;
        r_xmin <= w_xmin_nxt;
        r_xmax <= w_xmax_nxt;
      end
    end
  end

  reflex_lif_neuron #(
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_neuron (
    .clk           (clk),
    .rst           (rst),
    .update        (r_met_vld),
    .drift_spk     (r_drift_spk),
    .spread_spk    (r_spread_spk),
    .shock_spk     (r_shock_spk),
    .w_drift       (w_drift),
    .w_spread      (w_spread),
    .w_shock       (w_shock),
    .snn_threshold (snn_threshold),
    .fire_now      (w_fire_now),
    .fire          (reflex_active)
  );

`ifdef REFLEX_LATCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            override_status <= 1'b0;
    else if (w_fire_now) override_status <= 1'b1;
  end
`else
  localparam int c_HOLD_W = $clog2(HOLD_LINES + 1);
  logic [c_HOLD_W-1:0] r_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold          <= '0;
      override_status <= 1'b0;
    end else if (w_fire_now) begin
      r_hold          <= c_HOLD_W'(HOLD_LINES);
      override_status <= 1'b1;
    end else if (r_met_vld && (r_hold != '0)) begin
      r_hold <= r_hold - c_HOLD_W'(1);
      if (r_hold == c_HOLD_W'(1)) override_status <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) final_command <= '0;
    else      final_command <= override_status ? safe_torque : policy_torque;
  end

endmodule
`default_nettype wire

// File: tb/tb_top_reflex_system.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_top_reflex_system : directed self-checking bench for top_reflex_system |
// | Revision             : 1.0                                                |
// +--------------------------------------------------------------------------+
module tb_top_reflex_system;

`ifdef REFLEX_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               valid_pixel;
  logic               end_of_line;
  logic [7:0]         pixel_val;
  logic [9:0]         x_coord;
  logic [9:0]         center_x;
  logic signed [15:0] policy_torque;
  logic [23:0]        drift_thresh;
  logic [31:0]        spread_thresh;
  logic [23:0]        change_thresh;
  logic [15:0]        w_drift;
  logic [15:0]        w_spread;
  logic [15:0]        w_shock;
  logic [15:0]        snn_threshold;
  logic signed [15:0] safe_torque;
  logic signed [15:0] final_command;
  logic               reflex_active;
  logic               override_status;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] fire_pat;

  top_reflex_system dut (
    .clk             (clk),
    .rst             (rst),
    .valid_pixel     (valid_pixel),
    .end_of_line     (end_of_line),
    .pixel_val       (pixel_val),
    .x_coord         (x_coord),
    .center_x        (center_x),
    .policy_torque   (policy_torque),
    .drift_thresh    (drift_thresh),
    .spread_thresh   (spread_thresh),
    .change_thresh   (change_thresh),
    .w_drift         (w_drift),
    .w_spread        (w_spread),
    .w_shock         (w_shock),
    .snn_threshold   (snn_threshold),
    .safe_torque     (safe_torque),
    .final_command   (final_command),
    .reflex_active   (reflex_active),
    .override_status (override_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // n pixels from x0, end_of_line on the last pixel (or alone when n == 0).
  // Returns at the first negedge where reflex_active for this line is visible.
  task automatic run_line(input int x0, input int n, input int val);
    for (int i = 0; i < n; i++) begin
      valid_pixel = 1'b1;
      pixel_val   = 8'(val);
      x_coord     = 10'(x0 + i);
      end_of_line = (i == n - 1);
      @(negedge clk);
    end
    if (n == 0) begin
      end_of_line = 1'b1;
      @(negedge clk);
    end
    valid_pixel = 1'b0;
    end_of_line = 1'b0;
    pixel_val   = 8'd0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    valid_pixel   = 1'b0;
    end_of_line   = 1'b0;
    pixel_val     = 8'd0;
    x_coord       = 10'd0;
    center_x      = 10'd300;
    policy_torque = 16'sd1000;
    safe_torque   = 16'sd0;
    drift_thresh  = 24'd500;
    spread_thresh = 32'd1000;
    change_thresh = 24'd200;
    w_drift       = 16'd50;
    w_spread      = 16'd10;
    w_shock       = 16'd200;
    snn_threshold = 16'd150;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset_final_command", final_command, 16'd0);
    check_value("reset_reflex_active", {15'd0, reflex_active}, 16'd0);
    check_value("reset_override", {15'd0, override_status}, 16'd0);
    rst = 1'b1;
    @(negedge clk);

    // Centred object: S1 = -500, D = 500 sits exactly on the threshold.
    for (int l = 0; l < 5; l++) begin
      run_line(295, 10, 100);
      check_value("centred_no_fire", {15'd0, reflex_active}, 16'd0);
      check_value("centred_no_override", {15'd0, override_status}, 16'd0);
    end
    @(negedge clk);
    check_value("centred_cmd", final_command, 16'd1000);

    // Step to S1 = 9500: drift + shock, Vn = 250.
    run_line(305, 10, 100);
    check_value("step_fire", {15'd0, reflex_active}, 16'd1);
    check_value("step_override", {15'd0, override_status}, 16'd1);
    check_value("step_cmd_lags", final_command, 16'd1000);
    @(negedge clk);
    check_value("step_pulse_one_cycle", {15'd0, reflex_active}, 16'd0);
    check_value("step_cmd_safe", final_command, 16'd0);

    // S1 = 49500: shock on the first line, then drift builds V = 50, 94, 133, 167.
    fire_pat = 5'b10001;
    for (int l = 0; l < 5; l++) begin
      run_line(345, 10, 100);
      check_value("far_fire", {15'd0, reflex_active}, {15'd0, fire_pat[l]});
      check_value("far_override_held", {15'd0, override_status}, 16'd1);
    end

    // Empty lines count down the hold window from the last fire.
    for (int l = 0; l < 8; l++) begin
      run_line(0, 0, 0);
      check_value("empty_no_fire", {15'd0, reflex_active}, 16'd0);
      check_value("hold_countdown", {15'd0, override_status}, {15'd0, (l < 7) || LATCH});
    end
    @(negedge clk);
    check_value("release_cmd", final_command, LATCH ? 16'd0 : 16'd1000);

    // prev_moment survived the empty lines, so no shock: drift only, V = 50.
    run_line(345, 10, 100);
    check_value("prev_kept_no_fire", {15'd0, reflex_active}, 16'd0);

    // Constant drift with shock disabled.
    pulse_reset();
    change_thresh = 24'hFFFFFF;
    safe_torque   = -16'sd1234;
    fire_pat      = 5'b01000;
    for (int l = 0; l < 4; l++) begin
      run_line(345, 10, 100);
      check_value("drift_leak_fire", {15'd0, reflex_active}, {15'd0, fire_pat[l]});
    end
    @(negedge clk);
    check_value("drift_cmd_safe", final_command, 16'hFB2E);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b0;
    #1;
    check_value("async_rst_cmd", final_command, 16'd0);
    check_value("async_rst_override", {15'd0, override_status}, 16'd0);
    check_value("async_rst_fire", {15'd0, reflex_active}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Partial off-centre line killed by reset must not leak into the next line.
    w_drift = 16'd200;
    for (int i = 0; i < 3; i++) begin
      valid_pixel = 1'b1;
      pixel_val   = 8'd100;
      x_coord     = 10'(900 + i);
      @(negedge clk);
    end
    valid_pixel = 1'b0;
    pulse_reset();
    run_line(295, 10, 100);
    check_value("partial_discarded", {15'd0, reflex_active}, 16'd0);
    run_line(305, 10, 100);
    check_value("drift_weight_fire", {15'd0, reflex_active}, 16'd1);

    // Spread spike at its strict boundary.
    pulse_reset();
    w_drift       = 16'd0;
    w_shock       = 16'd0;
    w_spread      = 16'd200;
    spread_thresh = 32'd9;
    run_line(295, 10, 100);
    check_value("spread_at_thresh", {15'd0, reflex_active}, 16'd0);
    run_line(295, 11, 100);
    check_value("spread_over_thresh", {15'd0, reflex_active}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
